// File: rtl/fetch_unit.sv
// Instruction fetch front end.
// Issues sequential PCs to the instruction memory, keeps the number of granted
// but unreturned requests within both a fixed cap and the fetch queue's free
// slots, and pushes {pc, instr} pairs into the fetch queue. A redirect reloads
// both PCs and turns every request still in flight into a stale one whose
// response is silently consumed when it comes back.

module fetch_unit #(
    parameter int unsigned           pc_width_p        = 32,
    parameter int unsigned           instr_width_p     = 32,
    parameter logic [pc_width_p-1:0] reset_pc_p        = 32'h0000_0000,
    parameter int unsigned           max_outstanding_p = 2,
    parameter int unsigned           fq_els_p          = 16
) (
    input  logic                                clk_i,
    input  logic                                reset_ni,

    input  logic                                redirect_i,
    input  logic [pc_width_p-1:0]               redirect_pc_i,

    output logic                                imem_req_o,
    output logic [pc_width_p-1:0]               imem_addr_o,
    input  logic                                imem_gnt_i,
    input  logic                                imem_rvalid_i,
    input  logic [instr_width_p-1:0]            imem_rdata_i,

    input  logic [$clog2(fq_els_p):0]           fq_free_i,
    output logic                                fq_wr_o,
    output logic [pc_width_p+instr_width_p-1:0] fq_wr_data_o
);

    // Counter and comparison widths. Both counters hold 0..max_outstanding_p;
    // the credit compare is done at the wider of the counter and free-slot widths.
    localparam int unsigned cnt_w_lp  = $clog2(max_outstanding_p + 1);
    localparam int unsigned free_w_lp = $clog2(fq_els_p) + 1;
    localparam int unsigned cmp_w_lp  = (cnt_w_lp > free_w_lp) ? cnt_w_lp : free_w_lp;

    localparam logic [cnt_w_lp-1:0]   max_out_lp  = cnt_w_lp'(max_outstanding_p);
    localparam logic [cnt_w_lp-1:0]   cnt_one_lp  = cnt_w_lp'(1'b1);
    localparam logic [cnt_w_lp-1:0]   cnt_zero_lp = cnt_w_lp'(1'b0);
    localparam logic [pc_width_p-1:0] pc_step_lp  = pc_width_p'(32'd4);

    typedef enum logic [0:0] {
        BOOT_S  = 1'b0,
        FETCH_S = 1'b1
    } state_e;

    // Architectural state
    state_e                  state_q,       state_d;
    logic [pc_width_p-1:0]   req_pc_q,      req_pc_d;
    logic [pc_width_p-1:0]   rsp_pc_q,      rsp_pc_d;
    logic [cnt_w_lp-1:0]     outstanding_q, outstanding_d;
    logic [cnt_w_lp-1:0]     drop_cnt_q,    drop_cnt_d;

    // Combinational control
    logic                    fetching_s;
    logic [cmp_w_lp-1:0]     out_ext_s;
    logic [cmp_w_lp-1:0]     free_ext_s;
    logic                    req_s;
    logic                    grant_s;
    logic                    rsp_taken_s;
    logic                    retire_s;
    logic                    push_s;
    logic                    discard_s;
    logic [cnt_w_lp-1:0]     in_flight_left_s;

    assign fetching_s = (state_q == FETCH_S);
    assign out_ext_s  = cmp_w_lp'(outstanding_q);
    assign free_ext_s = cmp_w_lp'(fq_free_i);

    // A request may only go out while it can still be guaranteed a queue slot
    // on return, so the in-flight count must stay strictly below the free count.
    assign req_s   = fetching_s
                   & ~redirect_i
                   & (outstanding_q < max_out_lp)
                   & (out_ext_s < free_ext_s);
    assign grant_s = req_s & imem_gnt_i;

    // A returning response always retires one in-flight slot. The non-zero
    // guard only protects the counter against a spurious response.
    assign rsp_taken_s = imem_rvalid_i & (outstanding_q != cnt_zero_lp);
    assign retire_s    = rsp_taken_s & ~redirect_i;

    // Live responses are pushed; those issued before a redirect are discarded.
    assign push_s    = fetching_s & imem_rvalid_i & ~redirect_i & (drop_cnt_q == cnt_zero_lp);
    assign discard_s = imem_rvalid_i & ~redirect_i & (drop_cnt_q != cnt_zero_lp);

    // On a redirect, everything still in flight after this cycle's response is stale.
    assign in_flight_left_s = rsp_taken_s ? (outstanding_q - cnt_one_lp) : outstanding_q;

    // BOOT lasts exactly one cycle after reset release; FETCH is held until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT_S:  state_d = FETCH_S;
            FETCH_S: state_d = FETCH_S;
            default: state_d = BOOT_S;
        endcase
    end

    // Next-state for the PCs and the in-flight/stale counters; redirect dominates.
    always_comb begin
        req_pc_d      = req_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect_i) begin
            req_pc_d      = redirect_pc_i;
            rsp_pc_d      = redirect_pc_i;
            outstanding_d = in_flight_left_s;
            drop_cnt_d    = in_flight_left_s;
        end else begin
            if (grant_s) begin
                req_pc_d = req_pc_q + pc_step_lp;
            end else begin
                req_pc_d = req_pc_q;
            end

            if (push_s) begin
                rsp_pc_d = rsp_pc_q + pc_step_lp;
            end else begin
                rsp_pc_d = rsp_pc_q;
            end

            if (discard_s) begin
                drop_cnt_d = drop_cnt_q - cnt_one_lp;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end

            // A grant and a response in the same cycle cancel out.
            case ({grant_s, retire_s})
                2'b10:   outstanding_d = outstanding_q + cnt_one_lp;
                2'b01:   outstanding_d = outstanding_q - cnt_one_lp;
                default: outstanding_d = outstanding_q;
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= BOOT_S;
            req_pc_q      <= reset_pc_p;
            rsp_pc_q      <= reset_pc_p;
            outstanding_q <= cnt_zero_lp;
            drop_cnt_q    <= cnt_zero_lp;
        end else begin
            state_q       <= state_d;
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign imem_req_o   = req_s;
    assign imem_addr_o  = req_pc_q;
    assign fq_wr_o      = push_s;
    assign fq_wr_data_o = {rsp_pc_q, imem_rdata_i};

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A behavioural model keeps the list of
// requests in flight (each tagged live or stale), the next fetch PC, a memory
// that answers in order after a random latency and a fetch queue that drains
// at random. Every cycle the model predicts the DUT's request, address and push.

module tb_fetch_unit;

    localparam int MAXO = 2;
    localparam int FQ   = 16;

    logic        clk;
    logic        reset_ni;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [4:0]  fq_free_i;
    logic        fq_wr_o;
    logic [63:0] fq_wr_data_o;

    fetch_unit #(
        .pc_width_p        (32),
        .instr_width_p     (32),
        .reset_pc_p        (32'h0000_0000),
        .max_outstanding_p (MAXO),
        .fq_els_p          (FQ)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .fq_free_i     (fq_free_i),
        .fq_wr_o       (fq_wr_o),
        .fq_wr_data_o  (fq_wr_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
        int          ready;
        logic [31:0] data;
    } ent_t;

    ent_t        infl[$];
    logic [31:0] m_req_pc;
    bit          m_fetch;
    int          fq_cnt;
    int          cyc;

    int gnt_pct, lat_lo, lat_hi, drain_pct, fq_min;
    bit xor_data;

    bit          c_redir, c_gnt, c_rv;
    logic [31:0] c_rpc;
    logic        e_req, e_wr;
    logic [31:0] e_addr;
    logic [63:0] e_data;

    int errors = 0;
    int checks = 0;

    task automatic set_env(input int g, input int llo, input int lhi, input int d, input int fmin, input bit xd);
        gnt_pct = g; lat_lo = llo; lat_hi = lhi; drain_pct = d; fq_min = fmin; xor_data = xd;
    endtask

    // Reset DUT and model; returns at the negedge where reset is released.
    task automatic apply_reset();
        @(negedge clk);
        reset_ni = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; fq_free_i = 5'd16;
        infl.delete(); m_req_pc = 32'h0; m_fetch = 1'b0; fq_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        reset_ni = 1'b1;
    endtask

    // Drive one cycle's inputs (at a negedge) and form the model's predictions.
    task automatic begin_cycle(input bit redir, input logic [31:0] rpc);
        cyc++;
        c_redir = redir; c_rpc = rpc;
        c_gnt = (int'($urandom_range(99)) < gnt_pct);
        c_rv  = (infl.size() > 0) && (infl[0].ready <= cyc);
        redirect_i    = redir;
        redirect_pc_i = rpc;
        imem_gnt_i    = c_gnt;
        imem_rvalid_i = c_rv;
        imem_rdata_i  = c_rv ? infl[0].data : $urandom();
        fq_free_i     = 5'(FQ - fq_cnt);
        #1;
        e_req  = m_fetch && !redir && (infl.size() < MAXO) && (infl.size() < (FQ - fq_cnt));
        e_addr = m_req_pc;
        e_wr   = m_fetch && c_rv && !redir && !infl[0].stale;
        e_data = c_rv ? {infl[0].pc, infl[0].data} : 64'h0;
    endtask

    // Advance the model over the coming clock edge, then wait for the next negedge.
    task automatic end_cycle();
        ent_t ne;
        if (c_rv) void'(infl.pop_front());
        if (c_redir) begin
            foreach (infl[i]) infl[i].stale = 1'b1;
            m_req_pc = c_rpc;
            fq_cnt   = 0;
        end else begin
            if (e_req && c_gnt) begin
                ne.pc    = m_req_pc;
                ne.stale = 1'b0;
                ne.ready = cyc + int'($urandom_range(lat_hi, lat_lo));
                ne.data  = xor_data ? (m_req_pc ^ 32'h0000_FFFF) : $urandom();
                infl.push_back(ne);
                m_req_pc = m_req_pc + 32'd4;
            end
            if (e_wr) fq_cnt++;
            if (fq_cnt > fq_min && int'($urandom_range(99)) < drain_pct) fq_cnt--;
        end
        m_fetch = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h40;
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1234_5678; fq_free_i = 5'd16;
        #3;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req_o); end
        checks++; if (fq_wr_o !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", fq_wr_o); end
        checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=00000000", imem_addr_o); end
    endtask

    task automatic test_sequential();
        int pushes = 0;
        set_env(100, 1, 1, 100, 0, 1'b1);
        apply_reset();
        for (int i = 1; i <= 20; i++) begin
            begin_cycle(1'b0, 32'h0);
            checks++; if (imem_req_o !== e_req) begin errors++; $display("FAIL seq_req cyc=%0d got=%b exp=%b", i, imem_req_o, e_req); end
            checks++; if (imem_addr_o !== e_addr) begin errors++; $display("FAIL seq_addr cyc=%0d got=%h exp=%h", i, imem_addr_o, e_addr); end
            checks++; if (fq_wr_o !== e_wr) begin errors++; $display("FAIL seq_wr cyc=%0d got=%b exp=%b", i, fq_wr_o, e_wr); end
            if (e_wr) begin checks++; if (fq_wr_data_o !== e_data) begin errors++; $display("FAIL seq_data cyc=%0d got=%h exp=%h", i, fq_wr_data_o, e_data); end end
            if (i == 3) begin checks++; if (fq_wr_o !== 1'b1 || fq_wr_data_o !== 64'h0000_0000_0000_FFFF) begin errors++; $display("FAIL seq_first_push wr=%b got=%h exp=000000000000ffff", fq_wr_o, fq_wr_data_o); end end
            if (i == 4) begin checks++; if (fq_wr_data_o !== 64'h0000_0004_0000_FFFB) begin errors++; $display("FAIL seq_second_push got=%h exp=000000040000fffb", fq_wr_data_o); end end
            if (fq_wr_o === 1'b1) pushes++;
            end_cycle();
        end
        checks++; if (pushes != 18) begin errors++; $display("FAIL seq_throughput got=%0d exp=18", pushes); end
    endtask

    task automatic test_credit();
        int obs_out = 0, max_out = 0, bad_push = 0;
        set_env(100, 3, 3, 100, 15, 1'b0);
        apply_reset();
        fq_cnt = 15;
        for (int i = 0; i < 45; i++) begin
            if (i == 30) drain_pct = 0;
            begin_cycle(1'b0, 32'h0);
            checks++; if (imem_req_o !== e_req) begin errors++; $display("FAIL credit_req cyc=%0d got=%b exp=%b", i, imem_req_o, e_req); end
            checks++; if (fq_wr_o !== e_wr) begin errors++; $display("FAIL credit_wr cyc=%0d got=%b exp=%b", i, fq_wr_o, e_wr); end
            if (e_wr) begin checks++; if (fq_wr_data_o !== e_data) begin errors++; $display("FAIL credit_data cyc=%0d got=%h exp=%h", i, fq_wr_data_o, e_data); end end
            if (fq_wr_o === 1'b1 && fq_free_i == 5'd0) bad_push++;
            obs_out = obs_out + ((imem_req_o === 1'b1 && c_gnt) ? 1 : 0) - (c_rv ? 1 : 0);
            if (obs_out > max_out) max_out = obs_out;
            end_cycle();
        end
        checks++; if (max_out > 1) begin errors++; $display("FAIL credit_max_outstanding got=%0d exp<=1", max_out); end
        checks++; if (bad_push != 0) begin errors++; $display("FAIL credit_push_when_full got=%0d exp=0", bad_push); end
    endtask

    task automatic test_redirect();
        bit found = 1'b0, pushed = 1'b0;
        set_env(100, 3, 3, 100, 0, 1'b0);
        apply_reset();
        for (int i = 0; i < 60 && !found; i++) begin
            if (infl.size() == 2 && infl[0].pc == 32'h10) found = 1'b1;
            else begin
                begin_cycle(1'b0, 32'h0);
                checks++; if (imem_req_o !== e_req || imem_addr_o !== e_addr) begin errors++; $display("FAIL redir_pre req=%b/%b addr=%h/%h (got/exp)", imem_req_o, e_req, imem_addr_o, e_addr); end
                checks++; if (fq_wr_o !== e_wr || (e_wr && fq_wr_data_o !== e_data)) begin errors++; $display("FAIL redir_pre_push wr=%b/%b data=%h/%h (got/exp)", fq_wr_o, e_wr, fq_wr_data_o, e_data); end
                end_cycle();
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL redir_setup got=not_reached exp=two_in_flight_at_0x10"); end
        begin_cycle(1'b1, 32'h200);
        checks++; if (imem_req_o !== 1'b0 || fq_wr_o !== 1'b0) begin errors++; $display("FAIL redir_cycle req=%b wr=%b exp=0/0", imem_req_o, fq_wr_o); end
        end_cycle();
        for (int i = 0; i < 30 && !pushed; i++) begin
            begin_cycle(1'b0, 32'h0);
            if (i == 0) begin checks++; if (imem_addr_o !== 32'h200) begin errors++; $display("FAIL redir_next_addr got=%h exp=00000200", imem_addr_o); end end
            checks++; if (imem_req_o !== e_req || imem_addr_o !== e_addr) begin errors++; $display("FAIL redir_post req=%b/%b addr=%h/%h (got/exp)", imem_req_o, e_req, imem_addr_o, e_addr); end
            checks++; if (fq_wr_o !== e_wr) begin errors++; $display("FAIL redir_post_wr got=%b exp=%b", fq_wr_o, e_wr); end
            if (fq_wr_o === 1'b1) begin
                pushed = 1'b1;
                checks++; if (fq_wr_data_o[63:32] !== 32'h200) begin errors++; $display("FAIL redir_first_push_pc got=%h exp=00000200", fq_wr_data_o[63:32]); end
            end
            end_cycle();
        end
        checks++; if (!pushed) begin errors++; $display("FAIL redir_no_push got=none exp=push_of_0x200"); end
    endtask

    task automatic test_redirect_rvalid();
        bit pushed = 1'b0;
        set_env(100, 3, 3, 100, 0, 1'b0);
        apply_reset();
        for (int i = 0; i < 10 && infl.size() != 1; i++) begin begin_cycle(1'b0, 32'h0); end_cycle(); end
        gnt_pct = 0;
        for (int i = 0; i < 10 && !(infl.size() == 1 && infl[0].ready == cyc + 1); i++) begin begin_cycle(1'b0, 32'h0); end_cycle(); end
        begin_cycle(1'b1, 32'h200);
        checks++; if (imem_rvalid_i !== 1'b1 || fq_wr_o !== 1'b0) begin errors++; $display("FAIL redrv_consume rvalid=%b wr=%b exp=1/0", imem_rvalid_i, fq_wr_o); end
        end_cycle();
        gnt_pct = 100;
        begin_cycle(1'b0, 32'h0);
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin errors++; $display("FAIL redrv_next_req req=%b addr=%h exp=1/00000200", imem_req_o, imem_addr_o); end
        end_cycle();
        for (int i = 0; i < 20 && !pushed; i++) begin
            begin_cycle(1'b0, 32'h0);
            checks++; if (fq_wr_o !== e_wr || imem_req_o !== e_req) begin errors++; $display("FAIL redrv_post wr=%b/%b req=%b/%b (got/exp)", fq_wr_o, e_wr, imem_req_o, e_req); end
            if (fq_wr_o === 1'b1) begin
                pushed = 1'b1;
                checks++; if (fq_wr_data_o !== e_data || fq_wr_data_o[63:32] !== 32'h200) begin errors++; $display("FAIL redrv_push got=%h exp=%h", fq_wr_data_o, e_data); end
            end
            end_cycle();
        end
        checks++; if (!pushed) begin errors++; $display("FAIL redrv_no_push got=none exp=push_of_0x200"); end
    endtask

    task automatic test_hold();
        set_env(100, 1, 1, 100, 0, 1'b0);
        apply_reset();
        for (int i = 0; i < 20 && m_req_pc != 32'h8; i++) begin begin_cycle(1'b0, 32'h0); end_cycle(); end
        gnt_pct = 0;
        for (int i = 0; i < 5; i++) begin
            begin_cycle(1'b0, 32'h0);
            checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin errors++; $display("FAIL hold cyc=%0d req=%b addr=%h exp=1/00000008", i, imem_req_o, imem_addr_o); end
            end_cycle();
        end
        gnt_pct = 100;
        begin_cycle(1'b0, 32'h0);
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin errors++; $display("FAIL hold_grant req=%b addr=%h exp=1/00000008", imem_req_o, imem_addr_o); end
        end_cycle();
        begin_cycle(1'b0, 32'h0);
        checks++; if (imem_addr_o !== 32'hC) begin errors++; $display("FAIL hold_advance got=%h exp=0000000c", imem_addr_o); end
        end_cycle();
    endtask

    task automatic test_async_reset();
        set_env(100, 4, 4, 100, 0, 1'b0);
        apply_reset();
        for (int i = 0; i < 20 && !(infl.size() == 2 && infl[0].ready == cyc + 1); i++) begin begin_cycle(1'b0, 32'h0); end_cycle(); end
        begin_cycle(1'b0, 32'h0);
        checks++; if (fq_wr_o !== e_wr || e_wr !== 1'b1 || imem_addr_o !== 32'h8) begin errors++; $display("FAIL arst_pre wr=%b exp_wr=%b addr=%h exp=00000008", fq_wr_o, e_wr, imem_addr_o); end
        #2 reset_ni = 1'b0;
        #1;
        checks++; if (fq_wr_o !== 1'b0 || imem_req_o !== 1'b0) begin errors++; $display("FAIL arst_drop wr=%b req=%b exp=0/0", fq_wr_o, imem_req_o); end
        checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL arst_addr got=%h exp=00000000", imem_addr_o); end
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b0;
        infl.delete(); m_req_pc = 32'h0; m_fetch = 1'b0; fq_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        reset_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            begin_cycle(1'b0, 32'h0);
            if (i == 0) begin checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL arst_boot got=%b exp=0", imem_req_o); end end
            if (i == 1) begin checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL arst_restart req=%b addr=%h exp=1/00000000", imem_req_o, imem_addr_o); end end
            checks++; if (imem_req_o !== e_req || fq_wr_o !== e_wr || (e_wr && fq_wr_data_o !== e_data)) begin errors++; $display("FAIL arst_post req=%b/%b wr=%b/%b data=%h/%h (got/exp)", imem_req_o, e_req, fq_wr_o, e_wr, fq_wr_data_o, e_data); end
            end_cycle();
        end
    endtask

    task automatic test_random();
        bit          redir;
        logic [31:0] rpc;
        set_env(70, 1, 4, 60, 0, 1'b0);
        apply_reset();
        begin_cycle(1'b1, 32'h1000);
        checks++; if (imem_req_o !== 1'b0 || fq_wr_o !== 1'b0) begin errors++; $display("FAIL rnd_boot_redirect req=%b wr=%b exp=0/0", imem_req_o, fq_wr_o); end
        end_cycle();
        begin_cycle(1'b0, 32'h0);
        checks++; if (imem_addr_o !== 32'h1000 || imem_req_o !== 1'b1) begin errors++; $display("FAIL rnd_boot_pc addr=%h req=%b exp=00001000/1", imem_addr_o, imem_req_o); end
        end_cycle();
        for (int i = 0; i < 600; i++) begin
            if (i % 64 == 0) fq_min = int'($urandom_range(15, 0));
            redir = (int'($urandom_range(99)) < 8);
            rpc   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
            begin_cycle(redir, rpc);
            checks++; if (imem_req_o !== e_req) begin errors++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, imem_req_o, e_req); end
            checks++; if (imem_addr_o !== e_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_addr_o, e_addr); end
            checks++; if (fq_wr_o !== e_wr) begin errors++; $display("FAIL rnd_wr cyc=%0d got=%b exp=%b", cyc, fq_wr_o, e_wr); end
            if (e_wr) begin checks++; if (fq_wr_data_o !== e_data) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, fq_wr_data_o, e_data); end end
            end_cycle();
        end
    endtask

    initial begin
        cyc = 0;
        set_env(100, 1, 1, 100, 0, 1'b0);
        test_reset();
        test_sequential();
        test_credit();
        test_redirect();
        test_redirect_rvalid();
        test_hold();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
